// File: rtl/ch_instruction_sequencer_if.sv
// ch_instruction_sequencer_if: instruction valid/ready handshake into the sequencer
interface ch_instruction_sequencer_if;
    logic       instr_valid;
    logic [2:0] instr_code;
    logic       instr_ready;
    modport master (output instr_valid, output instr_code, input instr_ready);
    modport slave (input instr_valid, input instr_code, output instr_ready);
endinterface

// File: rtl/ch_instruction_sequencer.sv
// ch_instruction_sequencer: turns instructions into separated, mutually exclusive channel control pulses
module ch_instruction_sequencer #(
    parameter int PULSE_W = 4,
    parameter int DELAY_W = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    ch_instruction_sequencer_if.slave ins,
    input  logic                      auto_stop_en,
    input  logic [DELAY_W-1:0]        stop_delay,
    input  logic                      STOP_REQUEST,
    output logic                      INST_START,
    output logic                      start1,
    output logic                      start2,
    output logic                      start4,
    output logic                      INST_STOP,
    output logic                      INST_READOUT,
    output logic [2:0]                seq_state,
    output logic                      err_illegal
);
    typedef enum logic [2:0] {IDLE, ARMING, ARMED, DELAY, STOPPING, STOPPED, READING, READOUT} state_t;
    state_t state, state_n;
    logic [4:0] cnt, cnt_n;
    logic [DELAY_W-1:0] dly, dly_n;
    logic [1:0] code, code_n;
    logic [2:0] sync;
    logic [5:0] pulse_n;
    logic acc, arm, legal, err_n, edge_det;
    assign ins.instr_ready = !RST && state inside {IDLE, ARMED, DELAY, STOPPED, READOUT};
    assign acc = ins.instr_valid && ins.instr_ready;
    assign edge_det = sync[1] && !sync[2];
    assign seq_state = state;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt <= '0;
            dly <= '0;
            code <= '0;
            sync <= '0;
            err_illegal <= 1'b0;
            {INST_START, start1, start2, start4, INST_STOP, INST_READOUT} <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            dly <= dly_n;
            code <= code_n;
            sync <= {sync[1:0], STOP_REQUEST};
            err_illegal <= err_n;
            {INST_START, start1, start2, start4, INST_STOP, INST_READOUT} <= pulse_n;
        end
    end
    always_comb begin
        arm = ins.instr_code inside {3'd1, 3'd2, 3'd3};
        legal = ins.instr_code == 3'd0 || ins.instr_code == 3'd6
            || (arm && state inside {IDLE, STOPPED, READOUT})
            || (ins.instr_code == 3'd4 && state inside {ARMED, DELAY})
            || (ins.instr_code == 3'd5 && state == STOPPED);
        state_n = state;
        cnt_n = '0;
        dly_n = dly;
        code_n = code;
        err_n = acc ? (ins.instr_code != 3'd6 && (err_illegal || !legal)) : err_illegal;
        case (state)
            ARMING: begin
                state_n = cnt == 5'(2 * PULSE_W) ? ARMED : ARMING;
                cnt_n = cnt == 5'(2 * PULSE_W) ? '0 : cnt + 5'd1;
            end
            STOPPING, READING: begin
                state_n = cnt != 5'(PULSE_W - 1) ? state : (state == STOPPING ? STOPPED : READOUT);
                cnt_n = cnt == 5'(PULSE_W - 1) ? '0 : cnt + 5'd1;
            end
            ARMED: if (auto_stop_en && edge_det) begin
                state_n = DELAY;
                dly_n = stop_delay;
            end
            // an instruction accepted on the terminal count holds off the auto-stop
            DELAY: begin
                state_n = !acc && dly == '0 ? STOPPING : DELAY;
                dly_n = dly == '0 ? '0 : dly - DELAY_W'(1);
            end
            default: ;
        endcase
        if (acc && legal && arm) begin
            state_n = ARMING;
            code_n = ins.instr_code[1:0];
        end
        if (acc && legal && ins.instr_code == 3'd4) state_n = STOPPING;
        if (acc && legal && ins.instr_code == 3'd5) state_n = READING;
    end
    // pulses decode the upcoming state so they leave the flops already aligned
    always_comb begin
        pulse_n = '0;
        pulse_n[5] = state_n == ARMING && cnt_n < 5'(PULSE_W);
        pulse_n[4] = state_n == ARMING && cnt_n > 5'(PULSE_W) && code_n == 2'd1;
        pulse_n[3] = state_n == ARMING && cnt_n > 5'(PULSE_W) && code_n == 2'd2;
        pulse_n[2] = state_n == ARMING && cnt_n > 5'(PULSE_W) && code_n == 2'd3;
        pulse_n[1] = state_n == STOPPING;
        pulse_n[0] = state_n == READING;
    end
endmodule

// File: tb/tb_ch_instruction_sequencer.sv
// tb_ch_instruction_sequencer: directed scenarios plus random traffic against a pulse-schedule model
module tb_ch_instruction_sequencer;
    localparam int PW = 4;
    localparam int DW = 8;
    logic CLK = 1'b0, RST = 1'b1;
    logic auto_stop_en = 1'b0, STOP_REQUEST = 1'b0;
    logic [DW-1:0] stop_delay = '0;
    logic INST_START, start1, start2, start4, INST_STOP, INST_READOUT, err_illegal;
    logic [2:0] seq_state;
    logic [5:0] outs;
    int checks = 0, errors = 0;
    ch_instruction_sequencer_if ins();
    ch_instruction_sequencer #(.PULSE_W(PW), .DELAY_W(DW)) dut (
        .CLK(CLK), .RST(RST), .ins(ins), .auto_stop_en(auto_stop_en), .stop_delay(stop_delay),
        .STOP_REQUEST(STOP_REQUEST), .INST_START(INST_START), .start1(start1), .start2(start2),
        .start4(start4), .INST_STOP(INST_STOP), .INST_READOUT(INST_READOUT),
        .seq_state(seq_state), .err_illegal(err_illegal)
    );
    assign outs = {INST_START, start1, start2, start4, INST_STOP, INST_READOUT};
    always #5 CLK = ~CLK;

    // reference model: busy states replay a queue of per-cycle output vectors
    int m_state = 0, m_after = 0, m_dcnt = 0;
    logic m_err = 1'b0;
    logic [5:0] m_out = '0, prev_out = '0;
    logic [5:0] q[$];
    logic [2:0] hist = '0;
    bit mon_en = 1'b0;

    function automatic bit m_ready();
        return !RST && (m_state inside {0, 2, 3, 5, 7});
    endfunction

    task automatic begin_seq(int busy, int after, int c);
        q.delete();
        if (busy == 1) begin
            for (int i = 0; i < PW; i++) q.push_back(6'b100000);
            q.push_back(6'b000000);
            for (int i = 0; i < PW; i++) q.push_back(6'b010000 >> (c - 1));
        end else begin
            for (int i = 0; i < PW; i++) q.push_back(busy == 4 ? 6'b000010 : 6'b000001);
        end
        m_state = busy;
        m_after = after;
        m_out = q.pop_front();
    endtask

    task automatic model_step();
        bit acc, arm, legal, edge_now;
        int c;
        acc = ins.instr_valid && m_ready();
        c = int'(ins.instr_code);
        edge_now = hist[1] && !hist[2];
        if (RST) begin
            m_state = 0; m_out = '0; m_err = 1'b0; q.delete(); hist = '0; m_dcnt = 0;
            return;
        end
        hist = {hist[1:0], STOP_REQUEST};
        m_out = '0;
        if (m_state inside {1, 4, 6}) begin
            if (q.size() > 0) m_out = q.pop_front();
            else m_state = m_after;
            return;
        end
        arm = c inside {1, 2, 3};
        legal = c == 0 || c == 6 || (arm && (m_state inside {0, 5, 7}))
            || (c == 4 && (m_state inside {2, 3})) || (c == 5 && m_state == 5);
        if (m_state == 2 && auto_stop_en && edge_now) begin
            m_state = 3;
            m_dcnt = int'(stop_delay);
        end else if (m_state == 3) begin
            if (!acc && m_dcnt == 0) begin_seq(4, 5, 0);
            else if (m_dcnt > 0) m_dcnt--;
        end
        if (acc) begin
            if (c == 6) m_err = 1'b0;
            else if (!legal) m_err = 1'b1;
            if (legal && arm) begin_seq(1, 2, c);
            if (legal && c == 4) begin_seq(4, 5, 0);
            if (legal && c == 5) begin_seq(6, 7, 0);
        end
    endtask

    always @(negedge CLK) if (mon_en) begin
        checks++;
        if ({outs, seq_state, ins.instr_ready, err_illegal} !== {m_out, 3'(m_state), m_ready(), m_err}) begin
            errors++;
            $display("FAIL model t=%0t got out=%b st=%0d rdy=%b err=%b, expected out=%b st=%0d rdy=%b err=%b",
                $time, outs, seq_state, ins.instr_ready, err_illegal, m_out, m_state, m_ready(), m_err);
        end
        checks++;
        if ((outs & (outs - 6'd1)) != 0 || (prev_out != 0 && outs != 0 && outs != prev_out)) begin
            errors++;
            $display("FAIL exclusive_gap t=%0t got out=%b after %b, required one-hot with gap", $time, outs, prev_out);
        end
        prev_out = outs;
        model_step();
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [2:0] c);
        ins.instr_valid = 1'b1;
        ins.instr_code = c;
        tick();
        ins.instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        mon_en = 1'b1;
        tick();
        checks++;
        if ({outs, seq_state, ins.instr_ready, err_illegal} !== 11'b0) begin
            errors++;
            $display("FAIL reset_state got out=%b st=%0d rdy=%b err=%b, expected all 0", outs, seq_state, ins.instr_ready, err_illegal);
        end
        RST = 1'b0;
        tick();
        checks++;
        if (ins.instr_ready !== 1'b1 || seq_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_release got rdy=%b st=%0d, expected 1/0", ins.instr_ready, seq_state);
        end
    endtask

    task automatic test_arm_seq(input logic [2:0] c, input string name);
        logic [5:0] exp;
        issue(c);
        for (int i = 1; i <= 2 * PW + 2; i++) begin
            exp = {1'(i <= PW), (i >= PW + 2 && i <= 2 * PW + 1) ? (5'b10000 >> (c - 1)) : 5'b0};
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL %s cycle T+%0d got %b expected %b", name, i, outs, exp);
            end
            if (i < 2 * PW + 2) tick();
        end
        checks++;
        if (seq_state !== 3'd2 || ins.instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_armed got st=%0d rdy=%b expected 2/1", name, seq_state, ins.instr_ready);
        end
    endtask

    task automatic test_auto_stop();
        auto_stop_en = 1'b1;
        stop_delay = DW'(5);
        STOP_REQUEST = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            tick();
            checks++;
            if (INST_STOP !== 1'(i >= 9 && i <= 12)) begin
                errors++;
                $display("FAIL auto_stop tick %0d got INST_STOP=%b expected %b", i, INST_STOP, i >= 9 && i <= 12);
            end
            if ((i >= 3 && i <= 8 && seq_state !== 3'd3) || (i == 13 && seq_state !== 3'd5)) begin
                errors++;
                $display("FAIL auto_stop_state tick %0d got st=%0d", i, seq_state);
            end
        end
        STOP_REQUEST = 1'b0;
        auto_stop_en = 1'b0;
    endtask

    task automatic test_readout();
        issue(3'd5);
        for (int i = 1; i <= PW + 1; i++) begin
            checks++;
            if (outs !== {5'b0, 1'(i <= PW)}) begin
                errors++;
                $display("FAIL readout cycle T+%0d got %b expected INST_READOUT=%b only", i, outs, i <= PW);
            end
            if (i <= PW) tick();
        end
        checks++;
        if (seq_state !== 3'd7) begin
            errors++;
            $display("FAIL readout_state got %0d expected 7", seq_state);
        end
    endtask

    task automatic test_collision();
        int n_stop = 0;
        bit saw_delay = 1'b0;
        auto_stop_en = 1'b1;
        stop_delay = DW'(3);
        STOP_REQUEST = 1'b1;
        tick();
        tick();
        issue(3'd4);
        for (int i = 0; i < 12; i++) begin
            n_stop += int'(INST_STOP);
            saw_delay |= seq_state == 3'd3;
            tick();
        end
        checks++;
        if (n_stop != PW || saw_delay || seq_state !== 3'd5) begin
            errors++;
            $display("FAIL collision got stop_cycles=%0d delay_seen=%b st=%0d, expected %0d/0/5", n_stop, saw_delay, seq_state, PW);
        end
        STOP_REQUEST = 1'b0;
        auto_stop_en = 1'b0;
    endtask

    task automatic test_illegal();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        issue(3'd5);
        checks++;
        if (err_illegal !== 1'b1 || seq_state !== 3'd0 || outs !== 6'b0) begin
            errors++;
            $display("FAIL illegal_readout got err=%b st=%0d out=%b expected 1/0/0", err_illegal, seq_state, outs);
        end
        issue(3'd7);
        checks++;
        if (err_illegal !== 1'b1 || seq_state !== 3'd0 || ins.instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL illegal_code7 got err=%b st=%0d rdy=%b expected 1/0/1", err_illegal, seq_state, ins.instr_ready);
        end
        issue(3'd6);
        checks++;
        if (err_illegal !== 1'b0) begin
            errors++;
            $display("FAIL clear_err got err=%b expected 0", err_illegal);
        end
    endtask

    task automatic test_reset_mid();
        issue(3'd3);
        for (int i = 0; i < PW + 3; i++) tick();
        checks++;
        if (start4 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre got start4=%b expected 1", start4);
        end
        RST = 1'b1;
        tick();
        checks++;
        if (start4 !== 1'b0 || seq_state !== 3'd0 || ins.instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got start4=%b st=%0d rdy=%b expected 0/0/0", start4, seq_state, ins.instr_ready);
        end
        RST = 1'b0;
        tick();
        checks++;
        if (ins.instr_ready !== 1'b1 || outs !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid_release got rdy=%b out=%b expected 1/0", ins.instr_ready, outs);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            ins.instr_valid = $urandom_range(0, 2) == 0;
            ins.instr_code = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) STOP_REQUEST = ~STOP_REQUEST;
            if ($urandom_range(0, 49) == 0) auto_stop_en = ~auto_stop_en;
            stop_delay = DW'($urandom_range(0, 6));
            RST = $urandom_range(0, 499) == 0;
            tick();
        end
        RST = 1'b0;
        ins.instr_valid = 1'b0;
        tick();
        checks++;
        if (seq_state !== 3'(m_state) || err_illegal !== m_err) begin
            errors++;
            $display("FAIL random_end got st=%0d err=%b expected %0d/%b", seq_state, err_illegal, m_state, m_err);
        end
    endtask

    initial begin
        ins.instr_valid = 1'b0;
        ins.instr_code = 3'd0;
        test_reset();
        test_arm_seq(3'd2, "arm2");
        test_auto_stop();
        test_readout();
        test_arm_seq(3'd1, "arm1");
        test_collision();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ch_instruction_sequencer.md
# ch_instruction_sequencer

Single-clock initiator that drives the per-channel sampling control lines (INST_START, start1/start2/start4, INST_STOP, INST_READOUT) from an instruction stream. Sits between the chip's instruction/register interface and the channel state machines. Guarantees that control pulses are mutually exclusive and separated, which the channel state machines rely on. Watches the OR'd STOP_REQUEST return line and issues an automatic INST_STOP after a programmable delay.

## Interface
- PULSE_W, 4: cycles each control pulse is held high (legal range 2..15).
- DELAY_W, 8: width of the auto-stop delay counter.
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_code  in  3  0 NOP, 1 ARM1, 2 ARM2, 3 ARM4, 4 STOP, 5 READOUT, 6 CLEAR_ERR, 7 reserved.
- instr_ready  out  1  sequencer can accept; transfer when valid&ready on a posedge.
- auto_stop_en  in  1  enables STOP_REQUEST-driven stop.
- stop_delay  in  DELAY_W  cycles from detected STOP_REQUEST to INST_STOP; sampled on entry to DELAY.
- STOP_REQUEST  in  1  asynchronous, OR of channel requests.
- INST_START, start1, start2, start4, INST_STOP, INST_READOUT  out  1 each  registered control pulses.
- seq_state  out  3  current state encoding (below).
- err_illegal  out  1  sticky illegal-instruction flag.

## Operation
- States and encoding: IDLE=0, ARMING=1, ARMED=2, DELAY=3, STOPPING=4, STOPPED=5, READING=6, READOUT=7.
- instr_ready=1 only in IDLE, ARMED, DELAY, STOPPED, READOUT. It is 0 during reset.
- ARMx (codes 1-3) is legal in IDLE, STOPPED, READOUT. Transitions to ARMING:
  - INST_START pulse of PULSE_W cycles;
  - then one all-low gap cycle;
  - then a PULSE_W-cycle pulse on start1/start2/start4 per the code;
  - then ARMED.
- STOP (4) is legal in ARMED and DELAY. Goes to STOPPING: INST_STOP high for PULSE_W cycles, then STOPPED.
- READOUT (5) is legal in STOPPED only. Goes to READING: INST_READOUT high for PULSE_W cycles, then READOUT. The sequencer stays in READOUT until the next ARMx.
- NOP (0) is accepted with no effect. CLEAR_ERR (6) clears err_illegal in any ready state; the state is unchanged.
- Code 7, or any code illegal in the current state, is accepted and dropped. It sets err_illegal and leaves the state unchanged.
- STOP_REQUEST passes through a 2-flop synchronizer, then a rising-edge detector whose history flop runs in every state.
- In ARMED with auto_stop_en=1, a detected rising edge moves to DELAY and loads the counter with stop_delay.
- DELAY counter behaviour:
  - counter==0 in DELAY means STOPPING on the next cycle;
  - otherwise the counter decrements each cycle.
- Edges outside ARMED are ignored. A level that is already high on entry to ARMED does not trigger.
- At most one control output is high in any cycle. There is always at least one all-low cycle between different control pulses.

## Timing
- Reset: while RST is high on a posedge, all outputs go to 0, state goes to IDLE, counter 0, synchronizer and edge flops 0, err_illegal 0. instr_ready=1 in the first cycle after RST falls.
- Reset mid-pulse: the pulse drops at the first posedge with RST high. No partial sequence resumes.
- ARMx accepted at edge T:
  - INST_START high cycles T+1..T+PULSE_W;
  - gap at T+PULSE_W+1;
  - startN high T+PULSE_W+2..T+2·PULSE_W+1;
  - ARMED and ready at T+2·PULSE_W+2.
- STOP accepted at T: INST_STOP high T+1..T+PULSE_W; STOPPED at T+PULSE_W+1. READOUT uses the same timing with INST_READOUT.
- Auto-stop: synchronized rising edge seen at cycle S; DELAY from S+1; INST_STOP high S+D+2..S+D+PULSE_W+1, where D=stop_delay. D=0 gives INST_STOP at S+2.
- Simultaneous events:
  - a STOP instruction accepted in the same cycle as an edge in ARMED wins, and no DELAY is entered;
  - a STOP accepted in DELAY aborts the counter;
  - an instruction accepted in DELAY in the same cycle the counter hits 0 takes precedence over the auto-stop.
- auto_stop_en dropping while in DELAY does not cancel the pending stop.

## Test plan
- Reset, then ARM2 at T with PULSE_W=4 -> INST_START high T+1..T+4, all outputs low T+5, start2 high T+6..T+9, seq_state=2 at T+10, start1/start4 never high.
- ARMED with auto_stop_en=1, stop_delay=5, STOP_REQUEST raised and held -> seq_state=3 three cycles later, INST_STOP high for 4 cycles starting 7 cycles after synchronized edge, seq_state=5 after.
- From IDLE, issue READOUT, then code 7 -> both accepted, no pulses, err_illegal=1; CLEAR_ERR -> err_illegal=0.
- STOPPED, READOUT, then ARM1 -> INST_READOUT 4 cycles, seq_state=7, then full INST_START/start1 sequence; check the one-hot/gap invariant every cycle.
- RST asserted during 3rd cycle of start4 pulse -> start4=0 next edge, seq_state=0, instr_ready=1 first cycle after release.
- Manual STOP accepted in the same cycle as the synchronized STOP_REQUEST edge -> exactly one INST_STOP pulse of 4 cycles, DELAY never entered.
